spi_master_gen2: RTL and testbench
==================================

SPI_MASTER_GEN2 -- requirements
Module: spi_master_gen2

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 8, frame width in bits (2..32)
- NUM_SS, 4, number of slave-select lines (1..8)
- DIV_W, 8, width of clk_div
- SS_W, $clog2(NUM_SS) (min 1), width of ss_sel
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single system clock; all logic on rising edge
- rst, in, 1, reset, synchronous, active-high
- apb_ready, in, 1, start strobe; one-cycle request to launch a frame
- WDATA, in, DATA_W, transmit frame
- ss_sel, in, SS_W, slave to select
- cpol, in, 1, SCLK idle level
- cpha, in, 1, 0 = sample on leading edge, 1 = sample on trailing edge
- lsb_first, in, 1, 1 = shift LSB first
- clk_div, in, DIV_W, SCLK half-period = H = clk_div+1 clk cycles
- RDATA, out, DATA_W, last received frame
- rx_data_valid, out, 1, one-cycle pulse when RDATA updates
- SPI_status_RDY_BSYbar, out, 1, 1 = idle/ready, 0 = busy
- SCLK, out, 1, serial clock
- MOSI, out, 1, serial data out
- MISO, in, 1, serial data in
- SSbar, out, NUM_SS, active-low selects, one-hot-low when active

Function
REQ-003 FSM states SHALL be IDLE, SETUP, XFER, HOLD.
REQ-004 IDLE: apb_ready=1 with RDY=1 SHALL latch WDATA, ss_sel, cpol, cpha, lsb_first, clk_div and enter SETUP next cycle.
REQ-005 apb_ready while RDY=0 SHALL be ignored; no queuing.
REQ-006 SETUP entry: RDY=0, SSbar[ss_sel]=0, SCLK=cpol. If cpha=0, MOSI = first bit. SETUP lasts H cycles.
REQ-007 XFER SHALL produce exactly 2*DATA_W SCLK edges, one every H cycles; SCLK toggles from the latched cpol.
REQ-008 cpha=0: sample MISO on each odd (leading) edge and drive the next MOSI bit on each even edge. cpha=1: drive MOSI on each odd edge and sample on each even edge.
REQ-009 Bit order SHALL be MSB first when lsb_first=0 and LSB first otherwise, for both MOSI and the assembly of RDATA.
REQ-010 HOLD SHALL last H cycles with SCLK=cpol and SSbar held asserted; on exit: SSbar all ones, RDATA updated, rx_data_valid=1 for one cycle, RDY=1, state IDLE.
REQ-011 Latency: rx_data_valid SHALL assert exactly 1+H*(2*DATA_W+2) cycles after the cycle in which apb_ready is accepted.
REQ-012 apb_ready in the rx_data_valid cycle (RDY=1) SHALL be accepted; back-to-back frames are allowed.
REQ-013 IDLE outputs: SCLK follows the cpol input, registered; MOSI=0; SSbar all ones; RDATA holds its value.
REQ-014 If ss_sel >= NUM_SS, the frame SHALL run with full timing and RDATA update, but no SSbar bit asserts.
REQ-015 clk_div=0 (H=1) SHALL be supported; SCLK = clk/2.
REQ-016 Config input changes during a frame SHALL have no effect until the next accepted start.

Reset
REQ-017 When rst=1 at a clk edge, the next cycle SHALL show: state IDLE, SCLK=0, MOSI=0, SSbar all ones, RDATA=0, rx_data_valid=0, RDY=1.
REQ-018 Reset mid-frame SHALL abort the frame immediately with no rx_data_valid pulse and RDATA=0.

Verification
REQ-019 Mode 0, DATA_W=8, clk_div=0, WDATA=0xA5, MISO looped to MOSI -> MOSI serializes 1010_0101 MSB first; 16 SCLK edges; RDATA=0xA5; rx_data_valid pulse exactly 19 cycles after start.
REQ-020 Modes 1/2/3 with clk_div=3 and a bench slave returning 0x3C -> RDATA=0x3C in each mode; SCLK idle level = cpol; rx_data_valid at 1+4*18=73 cycles.
REQ-021 lsb_first=1, WDATA=0x01, ss_sel=2 -> first MOSI bit=1; only SSbar[2] low during the frame; SSbar=4'b1111 after HOLD.
REQ-022 apb_ready pulsed mid-frame, then again in the rx_data_valid cycle -> first pulse ignored; second frame starts with no idle gap.
REQ-023 rst asserted at the 5th SCLK edge -> next cycle SSbar all ones, RDY=1, RDATA=0, no rx_data_valid pulse.
REQ-024 ss_sel=5 with NUM_SS=4 -> SSbar stays 4'b1111; rx_data_valid still pulses at the nominal latency.

Source files
------------

// File: rtl/spi_master_gen2.sv
// spi_master_gen2 -- single-frame SPI master with per-frame mode, bit order,
// slave select and SCLK divider. All logic is on the rising edge of clk.
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   apb_ready              one-cycle start strobe, honoured only while ready
//   WDATA, ss_sel          frame to send and slave to address
//   cpol, cpha, lsb_first  SPI mode and bit order, latched at start
//   clk_div                SCLK half-period H = clk_div+1 clk cycles, latched
//   RDATA, rx_data_valid   last received frame and its one-cycle update pulse
//   SPI_status_RDY_BSYbar  1 = idle/ready, 0 = frame in progress
//   SCLK, MOSI, MISO       serial clock and data
//   SSbar                  active-low slave selects, one-hot-low during a frame
//
// Frame timing: SETUP (H) + XFER (2*DATA_W half-periods) + HOLD (H), then
// rx_data_valid in the first IDLE cycle.
module spi_master_gen2 #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apb_ready,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic [DATA_W-1:0] RDATA,
  output logic              rx_data_valid,
  output logic              SPI_status_RDY_BSYbar,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SSbar
);

  localparam int              EC_W      = $clog2(2 * DATA_W + 1);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [EC_W-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                valid_q, valid_d;
  logic [NUM_SS-1:0]   ssbar_q, ssbar_d;

  logic [NUM_SS-1:0]   ss_decode;
  logic                slot_end;
  logic [EC_W-1:0]     edge_nxt;
  logic                sample_edge;
  logic                take_edge;

  assign slot_end    = (cnt_q == div_q);
  assign edge_nxt    = edge_q + 1'b1;
  // Odd edges are leading edges: cpha=0 samples there, cpha=1 samples on even.
  assign sample_edge = edge_nxt[0] ^ cpha_q;

  // Out-of-range ss_sel leaves every select deasserted.
  always_comb begin
    ss_decode = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (32'(ss_sel) == i) ss_decode[i] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    valid_d   = 1'b0;
    ssbar_d   = ssbar_q;
    take_edge = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d  = cpol;
        mosi_d  = 1'b0;
        ssbar_d = '1;
        if (apb_ready) begin
          state_d = SETUP;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          div_d   = clk_div;
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          ssbar_d = ss_decode;
          if (cpha) begin
            mosi_d = 1'b0;
            tx_d   = WDATA;
          end else begin
            // cpha=0 presents the first bit before the leading edge, so it is
            // taken out of the shift register here.
            mosi_d = lsb_first ? WDATA[0] : WDATA[DATA_W-1];
            tx_d   = lsb_first ? (WDATA >> 1) : (WDATA << 1);
          end
        end
      end
      SETUP: begin
        if (slot_end) begin
          cnt_d     = '0;
          state_d   = XFER;
          take_edge = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (slot_end) begin
          cnt_d = '0;
          if (edge_q == LAST_EDGE) state_d = HOLD;
          else                     take_edge = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (slot_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          ssbar_d = '1;
          rdata_d = rx_q;
          valid_d = 1'b1;
          mosi_d  = 1'b0;
          sclk_d  = cpol;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_edge) begin
      edge_d = edge_nxt;
      sclk_d = ~sclk_q;
      if (sample_edge) begin
        rx_d = lsb_q ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
      end else if (edge_nxt != LAST_EDGE) begin
        // The final trailing edge in cpha=0 has no bit left to drive.
        mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
        tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      valid_q <= 1'b0;
      ssbar_q <= '1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      valid_q <= valid_d;
      ssbar_q <= ssbar_d;
    end
  end

  assign RDATA                 = rdata_q;
  assign rx_data_valid         = valid_q;
  assign SPI_status_RDY_BSYbar = (state_q == IDLE);
  assign SCLK                  = sclk_q;
  assign MOSI                  = mosi_q;
  assign SSbar                 = ssbar_q;

endmodule

// File: tb/tb_spi_master_gen2.sv
// tb_spi_master_gen2 -- directed bench for spi_master_gen2 (DATA_W=8,
// NUM_SS=4, ss_sel widened to 3 bits so an out-of-range select is reachable).
module tb_spi_master_gen2;

  localparam logic [7:0] SLV_WORD = 8'h3C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       apb_ready = 1'b0;
  logic [7:0] WDATA = '0;
  logic [2:0] ss_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] clk_div = '0;
  logic [7:0] RDATA;
  logic       rx_data_valid;
  logic       rdy;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;
  logic [3:0] SSbar;

  logic       loop_en = 1'b1;
  logic       slv_miso = 1'b0;
  logic       slv_act = 1'b0;
  int         slv_e = 0;
  logic [7:0] slv_sh = '0;

  int n_checks = 0;
  int n_errors = 0;

  spi_master_gen2 #(.DATA_W(8), .NUM_SS(4), .DIV_W(8), .SS_W(3)) dut (
    .clk(clk), .rst(rst), .apb_ready(apb_ready), .WDATA(WDATA),
    .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .clk_div(clk_div), .RDATA(RDATA), .rx_data_valid(rx_data_valid),
    .SPI_status_RDY_BSYbar(rdy), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .SSbar(SSbar)
  );

  always #5 clk = ~clk;

  assign MISO = loop_en ? MOSI : slv_miso;

  // MSB-first slave on select 0 returning SLV_WORD in the current mode.
  always @(SCLK or SSbar) begin
    if (SSbar[0] !== 1'b0) begin
      slv_act = 1'b0;
    end else if (!slv_act) begin
      slv_act  = 1'b1;
      slv_e    = 0;
      slv_sh   = SLV_WORD;
      slv_miso = cpha ? 1'b0 : slv_sh[7];
    end else begin
      slv_e++;
      if (cpha) begin
        if (slv_e % 2 == 1) begin
          slv_miso = slv_sh[7];
          slv_sh   = {slv_sh[6:0], 1'b0};
        end
      end else if (slv_e % 2 == 0) begin
        slv_sh   = {slv_sh[6:0], 1'b0};
        slv_miso = slv_sh[7];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (first cycle after the accepting edge).
  task automatic start_frame(input logic [7:0] wd, input logic [2:0] ss, input logic cp,
                             input logic ch, input logic lsb, input logic [7:0] div);
    WDATA = wd; ss_sel = ss; cpol = cp; cpha = ch; lsb_first = lsb; clk_div = div;
    tick();
    tick();
    check_eq("idle_sclk", SCLK, cp);
    apb_ready = 1'b1;
    tick();
    apb_ready = 1'b0;
  endtask

  // Observes a running frame until rx_data_valid; captures MOSI as seen at
  // each sampling SCLK edge (MSB-first order) and the busy-time SSbar.
  task automatic watch_frame(input int pulse_at, input logic [7:0] pulse_data,
                             output int lat, output int edges, output logic [7:0] cap,
                             output logic [3:0] ss_busy, output logic ss_stable);
    int   cyc;
    logic ps, pm;
    lat = -1; edges = 0; cap = '0; ss_busy = SSbar; ss_stable = 1'b1; cyc = 1;
    while (cyc < 2000) begin
      if (rx_data_valid === 1'b1) begin
        lat = cyc;
        break;
      end
      ps = SCLK;
      pm = MOSI;
      if (pulse_at != 0 && cyc == pulse_at) begin
        apb_ready = 1'b1;
        WDATA     = pulse_data;
        clk_div   = 8'd5;
      end
      tick();
      cyc++;
      apb_ready = 1'b0;
      if (SCLK !== ps) begin
        edges++;
        if (((edges % 2) == 1) != (cpha == 1'b1)) cap = {cap[6:0], pm};
      end
      if (rdy === 1'b0 && SSbar !== ss_busy) ss_stable = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int         lat, edges, e, pulses;
    logic [7:0] cap;
    logic [3:0] ssb;
    logic       sst, ps;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_sclk", SCLK, 1'b0);
    check_eq("rst_mosi", MOSI, 1'b0);
    check_eq("rst_ssbar", SSbar, 4'hF);
    check_eq("rst_rdata", RDATA, 8'h00);
    check_eq("rst_valid", rx_data_valid, 1'b0);
    check_eq("rst_rdy", rdy, 1'b1);
    rst = 1'b0;
    tick();

    // IDLE SCLK tracks cpol one cycle later
    cpol = 1'b1;
    tick();
    check_eq("idle_cpol1", SCLK, 1'b1);
    cpol = 1'b0;
    tick();
    check_eq("idle_cpol0", SCLK, 1'b0);

    // Mode 0, H=1, loopback 0xA5
    loop_en = 1'b1;
    start_frame(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    check_eq("m0_busy", rdy, 1'b0);
    watch_frame(0, 8'h00, lat, edges, cap, ssb, sst);
    check_eq("m0_lat", lat, 19);
    check_eq("m0_edges", edges, 16);
    check_eq("m0_mosi", cap, 8'hA5);
    check_eq("m0_ss_busy", ssb, 4'b1110);
    check_eq("m0_ss_stable", sst, 1'b1);
    check_eq("m0_rdata", RDATA, 8'hA5);
    check_eq("m0_rdy", rdy, 1'b1);
    check_eq("m0_ss_after", SSbar, 4'hF);
    tick();
    check_eq("m0_valid_1cyc", rx_data_valid, 1'b0);

    // Modes 1..3, H=4, slave returns 0x3C
    loop_en = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      start_frame(8'h96, 3'd0, (m >= 2), (m % 2 == 1), 1'b0, 8'd3);
      watch_frame(0, 8'h00, lat, edges, cap, ssb, sst);
      check_eq($sformatf("m%0d_lat", m), lat, 73);
      check_eq($sformatf("m%0d_edges", m), edges, 16);
      check_eq($sformatf("m%0d_mosi", m), cap, 8'h96);
      check_eq($sformatf("m%0d_rdata", m), RDATA, 8'h3C);
      check_eq($sformatf("m%0d_sclk_idle", m), SCLK, (m >= 2));
    end

    // LSB first, select 2, H=2
    loop_en = 1'b1;
    start_frame(8'h01, 3'd2, 1'b0, 1'b0, 1'b1, 8'd1);
    watch_frame(0, 8'h00, lat, edges, cap, ssb, sst);
    check_eq("lsb_lat", lat, 37);
    check_eq("lsb_first_bit", cap[7], 1'b1);
    check_eq("lsb_mosi", cap, 8'h80);
    check_eq("lsb_ss_busy", ssb, 4'b1011);
    check_eq("lsb_ss_stable", sst, 1'b1);
    check_eq("lsb_rdata", RDATA, 8'h01);
    check_eq("lsb_ss_after", SSbar, 4'hF);

    // Mid-frame start ignored (with config changes), then back-to-back start
    start_frame(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    watch_frame(5, 8'hFF, lat, edges, cap, ssb, sst);
    check_eq("b2b_a_lat", lat, 19);
    check_eq("b2b_a_edges", edges, 16);
    check_eq("b2b_a_mosi", cap, 8'h5A);
    check_eq("b2b_a_rdata", RDATA, 8'h5A);
    WDATA = 8'hC3;
    clk_div = 8'd0;
    apb_ready = 1'b1;
    tick();
    apb_ready = 1'b0;
    check_eq("b2b_b_busy", rdy, 1'b0);
    check_eq("b2b_b_ss", SSbar, 4'b1110);
    watch_frame(0, 8'h00, lat, edges, cap, ssb, sst);
    check_eq("b2b_b_lat", lat, 19);
    check_eq("b2b_b_mosi", cap, 8'hC3);
    check_eq("b2b_b_rdata", RDATA, 8'hC3);

    // Out-of-range select
    start_frame(8'h81, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0);
    watch_frame(0, 8'h00, lat, edges, cap, ssb, sst);
    check_eq("oor_ss_busy", ssb, 4'hF);
    check_eq("oor_ss_stable", sst, 1'b1);
    check_eq("oor_lat", lat, 19);
    check_eq("oor_rdata", RDATA, 8'h81);

    // Reset at the 5th SCLK edge
    start_frame(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    e = 0;
    for (int k = 0; k < 100 && e < 5; k++) begin
      ps = SCLK;
      tick();
      if (SCLK !== ps) e++;
    end
    check_eq("rst5_edge_seen", e, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst5_ssbar", SSbar, 4'hF);
    check_eq("rst5_rdy", rdy, 1'b1);
    check_eq("rst5_rdata", RDATA, 8'h00);
    check_eq("rst5_valid", rx_data_valid, 1'b0);
    check_eq("rst5_sclk", SCLK, 1'b0);
    check_eq("rst5_mosi", MOSI, 1'b0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rx_data_valid === 1'b1) pulses++;
    end
    check_eq("rst5_no_pulse", pulses, 0);
    check_eq("rst5_rdy_after", rdy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
